// File: rtl/tinyml_axi_wrr_arbiter_if.sv
// rtl/tinyml_axi_wrr_arbiter_if.sv - request/grant bundle between AXI masters and the WRR arbiter
interface tinyml_axi_wrr_arbiter_if #(
  parameter int PORTS    = 4,
  parameter int WEIGHT_W = 4
);
  localparam int IDX_W = $clog2(PORTS);

  logic [PORTS-1:0]          request;
  logic [PORTS-1:0]          acknowledge;
  logic [PORTS*WEIGHT_W-1:0] weight;
  logic [PORTS-1:0]          grant;
  logic                      grant_valid;
  logic [IDX_W-1:0]          grant_encoded;
  logic [WEIGHT_W-1:0]       credit;
  logic                      timeout;

  // master: the arbiter side that issues grants
  modport master (
    input  request, acknowledge, weight,
    output grant, grant_valid, grant_encoded, credit, timeout
  );

  // slave: the requester side
  modport slave (
    output request, acknowledge, weight,
    input  grant, grant_valid, grant_encoded, credit, timeout
  );
endinterface

// File: rtl/tinyml_axi_wrr_arbiter.sv
// rtl/tinyml_axi_wrr_arbiter.sv - weighted round-robin grant arbiter for the AXI AW/AR muxes
// Optional hold-without-ack release guarded by TINYML_AXI_ARB_TIMEOUT_EN.
module tinyml_axi_wrr_arbiter #(
  parameter int PORTS          = 4,
  parameter int WEIGHT_W       = 4,
  parameter     LSB_PRIORITY   = "LOW",
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                      clk,
  input logic                      rst_n,
  tinyml_axi_wrr_arbiter_if.master arb
);
  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [PORTS-1:0]    grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    enc_q, enc_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                ptr_vld_q, ptr_vld_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                timeout_q, timeout_d;

  logic [IDX_W-1:0]    base_idx, scan_idx, first_idx, fwd_idx, win;
  logic                base_vld, ahead, any_req, fwd_req, found;
  logic [WEIGHT_W-1:0] win_weight, win_credit;
  logic                ack_g, req_g, release_c, load_c, force_rel;

  // While holding, the current grant is the rotation base it will leave behind
  assign base_vld = (state_q == HOLD) ? 1'b1 : ptr_vld_q;
  assign base_idx = (state_q == HOLD) ? enc_q : ptr_q;

  // Scan in priority order from lowest to highest so the last hit wins
  always_comb begin
    scan_idx  = '0;
    ahead     = 1'b0;
    any_req   = 1'b0;
    fwd_req   = 1'b0;
    first_idx = '0;
    fwd_idx   = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      scan_idx = (LSB_PRIORITY == "HIGH") ? IDX_W'(PORTS - 1 - k) : IDX_W'(k);
      ahead    = (LSB_PRIORITY == "HIGH") ? (scan_idx < base_idx) : (scan_idx > base_idx);
      if (arb.request[scan_idx]) begin
        any_req   = 1'b1;
        first_idx = scan_idx;
        if (base_vld && ahead) begin
          fwd_req = 1'b1;
          fwd_idx = scan_idx;
        end
      end
    end
    found = any_req;
    win   = fwd_req ? fwd_idx : first_idx;
  end

  assign win_weight = arb.weight[int'(win)*WEIGHT_W +: WEIGHT_W];
  assign win_credit = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
  assign ack_g      = arb.acknowledge[enc_q];
  assign req_g      = arb.request[enc_q];

`ifdef TINYML_AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  assign force_rel  = (hold_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign hold_cnt_d = (state_q == HOLD && !ack_g && !release_c) ? hold_cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign force_rel          = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    enc_d     = enc_q;
    credit_d  = credit_q;
    ptr_d     = ptr_q;
    ptr_vld_d = ptr_vld_q;
    timeout_d = 1'b0;
    release_c = 1'b0;
    load_c    = 1'b0;

    case (state_q)
      IDLE: load_c = found;
      HOLD: begin
        if (ack_g) begin
          if (credit_q == WEIGHT_W'(1)) release_c = 1'b1;
          else                          credit_d  = credit_q - WEIGHT_W'(1);
        end else if (!req_g) begin
          release_c = 1'b1;
        end else if (force_rel) begin
          release_c = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_c) begin
      ptr_d     = enc_q;
      ptr_vld_d = 1'b1;
      load_c    = found;
      if (!found) begin
        grant_d  = '0;
        valid_d  = 1'b0;
        enc_d    = '0;
        credit_d = '0;
        state_d  = IDLE;
      end
    end

    // Hand-over loads on the release edge, so grant_valid never drops between owners
    if (load_c) begin
      grant_d      = '0;
      grant_d[win] = 1'b1;
      valid_d      = 1'b1;
      enc_d        = win;
      credit_d     = win_credit;
      state_d      = HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      enc_q     <= '0;
      credit_q  <= '0;
      ptr_q     <= '0;
      ptr_vld_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      enc_q     <= enc_d;
      credit_q  <= credit_d;
      ptr_q     <= ptr_d;
      ptr_vld_q <= ptr_vld_d;
      timeout_q <= timeout_d;
    end
  end

  assign arb.grant         = grant_q;
  assign arb.grant_valid   = valid_q;
  assign arb.grant_encoded = enc_q;
  assign arb.credit        = credit_q;
  assign arb.timeout       = timeout_q;
endmodule

// File: tb/tb_tinyml_axi_wrr_arbiter.sv
// tb/tb_tinyml_axi_wrr_arbiter.sv - scoreboard bench for the weighted round-robin arbiter
module tb_tinyml_axi_wrr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic rst_b;

  always #5 clk = ~clk;

  tinyml_axi_wrr_arbiter_if #(.PORTS(4), .WEIGHT_W(4)) aif ();
  tinyml_axi_wrr_arbiter_if #(.PORTS(4), .WEIGHT_W(4)) bif ();

  assign bif.request     = aif.request;
  assign bif.acknowledge = aif.acknowledge;
  assign bif.weight      = aif.weight;

  tinyml_axi_wrr_arbiter #(
    .PORTS(4), .WEIGHT_W(4), .LSB_PRIORITY("LOW"), .TIMEOUT_CYCLES(8)
  ) dut_lo (
    .clk(clk), .rst_n(rst_n), .arb(aif)
  );

  tinyml_axi_wrr_arbiter #(
    .PORTS(4), .WEIGHT_W(4), .LSB_PRIORITY("HIGH"), .TIMEOUT_CYCLES(8)
  ) dut_hi (
    .clk(clk), .rst_n(rst_b), .arb(bif)
  );

  typedef struct {
    bit    sel;
    string tag;
    logic  gv;
    int    enc;
    int    cr;
    logic  to;
  } exp_t;

  exp_t sbq[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input string tag, input logic gv, input int enc,
                      input int cr, input logic to);
    exp_t e;
    e.sel = sel; e.tag = tag; e.gv = gv; e.enc = enc; e.cr = cr; e.to = to;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [3:0] og, oc, eg;
    logic [1:0] oe;
    logic       ov, ot;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (!e.sel) begin
        og = aif.grant; ov = aif.grant_valid; oe = aif.grant_encoded; oc = aif.credit; ot = aif.timeout;
      end else begin
        og = bif.grant; ov = bif.grant_valid; oe = bif.grant_encoded; oc = bif.credit; ot = bif.timeout;
      end
      eg = e.gv ? (4'b0001 << e.enc) : 4'b0000;
      cmp({e.tag, ".grant"}, 32'(og), 32'(eg));
      cmp({e.tag, ".valid"}, 32'(ov), 32'(e.gv));
      cmp({e.tag, ".credit"}, 32'(oc), 32'(e.cr));
      cmp({e.tag, ".timeout"}, 32'(ot), 32'(e.to));
      if (e.enc >= 0) cmp({e.tag, ".encoded"}, 32'(oe), 32'(e.enc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rst_b = 1'b0;
    aif.request     = 4'b1111;
    aif.acknowledge = 4'b0000;
    aif.weight      = {4'd3, 4'd1, 4'd1, 4'd2};

    // Reset holds everything at zero despite requests
    repeat (2) @(posedge clk);
    #1;
    push(0, "reset", 0, 0, 0, 0);
    push(1, "reset_hi", 0, 0, 0, 0);
    drain();
    rst_n = 1'b1;
    push(0, "first_grant", 1, 0, 2, 0);
    tick();
    aif.request = 4'b0000;
    push(0, "idle_after_first", 0, -1, 0, 0);
    tick();

    // Weighted burst on port 3, then sole-requester re-grant without a bubble
    aif.request     = 4'b1000;
    aif.acknowledge = 4'b1000;
    push(0, "burst_c3", 1, 3, 3, 0); tick();
    push(0, "burst_c2", 1, 3, 2, 0); tick();
    push(0, "burst_c1", 1, 3, 1, 0); tick();
    push(0, "burst_regrant", 1, 3, 3, 0); tick();
    aif.request     = 4'b0000;
    aif.acknowledge = 4'b0000;
    push(0, "burst_idle", 0, -1, 0, 0); tick();

    // Rotation with unit weights on both priority orders
    aif.weight      = {4'd1, 4'd1, 4'd1, 4'd1};
    aif.request     = 4'b1111;
    aif.acknowledge = 4'b1111;
    rst_b           = 1'b1;
    begin
      int seq_lo[5] = '{0, 1, 2, 3, 0};
      int seq_hi[5] = '{3, 2, 1, 0, 3};
      for (int i = 0; i < 5; i++) begin
        push(0, $sformatf("rot_lo%0d", i), 1, seq_lo[i], 1, 0);
        push(1, $sformatf("rot_hi%0d", i), 1, seq_hi[i], 1, 0);
        tick();
      end
    end
    aif.request     = 4'b0000;
    aif.acknowledge = 4'b0000;
    push(0, "rot_idle_lo", 0, -1, 0, 0);
    push(1, "rot_idle_hi", 0, -1, 0, 0);
    tick();
    rst_b = 1'b0;

    // Weight 0 behaves as 1; foreign ack ignored; early release hands over
    aif.weight  = {4'd1, 4'd2, 4'd0, 4'd2};
    aif.request = 4'b0110;
    push(0, "w0_grant", 1, 1, 1, 0); tick();
    aif.acknowledge = 4'b0001;
    push(0, "foreign_ack", 1, 1, 1, 0); tick();
    aif.acknowledge = 4'b0000;
    aif.request     = 4'b0100;
    push(0, "early_release", 1, 2, 2, 0); tick();

    // Asynchronous reset while port 2 holds credit 2
    rst_n = 1'b0;
    #1;
    push(0, "async_reset", 0, 0, 0, 0);
    drain();
    rst_n = 1'b1;
    aif.request = 4'b1111;
    push(0, "post_reset_lowest", 1, 0, 2, 0); tick();
    aif.request = 4'b0000;
    push(0, "post_reset_idle", 0, -1, 0, 0); tick();

    // Stalled master: port 0 holds with no ack while port 1 waits
    aif.request = 4'b0001;
    push(0, "stall_grant", 1, 0, 2, 0); tick();
    aif.request = 4'b0011;
`ifdef TINYML_AXI_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      push(0, $sformatf("to_hold%0d", i), 1, 0, 2, 0);
      tick();
    end
    push(0, "to_fire", 1, 1, 1, 1); tick();
    push(0, "to_after", 1, 1, 1, 0); tick();
`else
    for (int i = 0; i < 100; i++) begin
      push(0, $sformatf("stall_hold%0d", i), 1, 0, 2, 0);
      tick();
    end
`endif
    aif.request = 4'b0000;
    push(0, "final_idle", 0, -1, 0, 0); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tinyml_axi_wrr_arbiter.md
Name: tinyml_axi_wrr_arbiter

Overview:
Weighted round-robin arbiter for the tinyml AXI interconnect. It replaces the flat priority/round-robin arbiter where masters need unequal bandwidth shares. A granted port holds the grant for up to its weight in acknowledged transfers, then the grant rotates. Zero-bubble hand-over between masters; sits in front of the AW/AR muxes of the tinyml AXI crossbar.

Parameters:
PORTS, 4, number of requesters (2..16)
WEIGHT_W, 4, bits per port weight; weight 0 is treated as 1
LSB_PRIORITY, "LOW", "LOW": lower index wins ties after the pointer; "HIGH": higher index wins
TIMEOUT_CYCLES, 256, hold-without-ack limit (used only with TINYML_AXI_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock; all logic rising-edge
rst_n  input  1  asynchronous active-low reset
request  input  PORTS  per-port request, level
acknowledge  input  PORTS  per-port transfer-complete strobe; one transfer per high cycle
weight  input  PORTS*WEIGHT_W  packed weights; port i at [i*WEIGHT_W +: WEIGHT_W]
grant  output  PORTS  one-hot grant, registered
grant_valid  output  1  grant is active, registered
grant_encoded  output  $clog2(PORTS)  index of granted port, registered
credit  output  WEIGHT_W  transfers remaining in current grant, registered
timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst_n low, asynchronous): grant=0, grant_valid=0, grant_encoded=0, credit=0, timeout=0, rotation pointer=0, FSM=IDLE, timeout counter=0.
- FSM states: IDLE, HOLD.
- IDLE: if any request bit is high, select the winner with round-robin from the pointer. The winner takes effect on the next edge: grant_valid=1, one-hot grant, encoded index, credit = max(weight[winner],1). Go to HOLD. Latency is 1 cycle from request to grant.
- Round-robin selection with LSB_PRIORITY "LOW": first requester with index > last granted index. If none, the lowest-index requester, including the last granted port. "HIGH" mirrors this with descending order.
- HOLD, each cycle, evaluated in this order:
  (a) acknowledge[granted]=1 and credit=1: release.
  (b) acknowledge[granted]=1 and credit>1: credit decrements by 1 and the grant holds.
  (c) request[granted]=0 with no ack: early release.
  (d) Otherwise hold with no change.
- Acknowledge on non-granted ports is ignored.
- Release:
  - Pointer := released index.
  - If any request (masked by current-cycle request) is pending, the next grant loads on the same edge as the release. grant_valid stays 1, there is no bubble, and credit is reloaded from the new winner's weight.
  - The released port is eligible again only if no other port requests.
  - If no requests are pending: grant=0, grant_valid=0, credit=0, FSM→IDLE.
- Weight is sampled only at grant time. Changes mid-grant take effect at the next grant.
- Simultaneous ack on the last credit and request drop on the same port count as a normal release (a).
- Reset mid-HOLD clears the grant immediately, asynchronously. After reset, arbitration resumes from pointer 0.
- grant is always one-hot or zero. grant_valid=1 iff grant≠0.

Optional Feature:
TINYML_AXI_ARB_TIMEOUT_EN
- Defined: a hold counter runs in HOLD, clears on every acknowledge[granted] and on each new grant, and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, the grant is force-released (same rules as a normal release) and timeout pulses high for 1 cycle, aligned with the new grant.
  - Timeout has higher priority than condition (d) and lower priority than (a)–(c).
- Not defined: no counter is built, timeout is tied 0, and a stalled master holds the grant indefinitely.

Test Plan:
- Reset/idle: rst_n low with request=4'b1111 → grant=0, grant_valid=0, credit=0. Release rst_n → cycle 1 after the first edge: grant=4'b0001, encoded=0, credit=weight[0].
- Weighted burst: weights {1,1,1,3} (port3=3), request=4'b1000, ack every cycle → grant holds 3 acks with credit 3→2→1. Then it re-grants port 3 (sole requester) with credit=3 and no bubble.
- Rotation: all ports requesting, all weights 1, ack every cycle → grant_encoded sequence 0,1,2,3,0 with grant_valid continuously 1. With LSB_PRIORITY="HIGH" the sequence is 3,2,1,0,3.
- Early release and weight-0: port1 weight=0 granted with credit=1. Dropping request[1] without ack → next cycle grants port 2 (requesting). Ack on port 0 while port 1 is granted does not change credit.
- Async reset mid-HOLD: rst_n pulsed low for 1 ns between edges while port 2 is granted with credit=2 → outputs zero immediately. The next grant after release goes to the lowest requester.
- Timeout (macro on, TIMEOUT_CYCLES=8): port 0 granted, request held, no ack → after 8 HOLD cycles, timeout=1 for 1 cycle and the grant moves to port 1. With the macro off, the grant stays on port 0 for 100 cycles and timeout stays 0.
